cmd_dispatch: RTL and testbench
===============================

CMD_DISPATCH -- requirements
Module: cmd_dispatch

Interface
REQ-001 Parameter CMD_WIDTH, default 4: command field width.
REQ-002 Parameter DATA_WIDTH, default 8: payload width, 8 to 24.
REQ-003 Parameter CALLBACK_WIDTH, default 8: per-target callback width.
REQ-004 Parameter N_TARGETS, default 4: number of command targets; command codes 0..N_TARGETS-1 are valid.
REQ-005 Parameter WAIT_CYCLES, default 4: cycles from en pulse to callback capture, minimum 3.
REQ-006 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-008 Port cmd_word_i, input, 32: PS command register; [31] strobe toggle, [27:24] command, [DATA_WIDTH-1:0] payload.
REQ-009 Port cb_i, input, N_TARGETS*CALLBACK_WIDTH: packed target callbacks; target k occupies slice [k*CALLBACK_WIDTH +: CALLBACK_WIDTH].
REQ-010 Port cmd_o, output, CMD_WIDTH: issued command, held until the next issue.
REQ-011 Port payload_o, output, DATA_WIDTH: issued payload, held until the next issue.
REQ-012 Port en_o, output, 1: single-cycle enable pulse to targets.
REQ-013 Port status_o, output, 32: [31] done, [30] invalid-cmd, [29] overrun (sticky), [27:24] command echo, [CALLBACK_WIDTH-1:0] captured callback, other bits 0.

Function
REQ-014 The block SHALL register cmd_word_i[31] every cycle and detect a new command on any change (toggle) of the registered bit.
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and LATCH; encoding 2 bits; illegal states return to IDLE.
REQ-016 IDLE->ISSUE on a detected toggle: cmd_o and payload_o load from cmd_word_i, and status_o[31] clears, in the same edge.
REQ-017 In ISSUE, en_o SHALL be 1 for exactly one cycle when the command is valid; ISSUE->WAIT always.
REQ-018 An invalid command (code >= N_TARGETS) SHALL produce no en_o pulse and SHALL set status_o[30]; the FSM still passes through WAIT and LATCH.
REQ-019 WAIT SHALL count WAIT_CYCLES-1 cycles with a counter of width $clog2(WAIT_CYCLES)+1, then go to LATCH.
REQ-020 LATCH SHALL capture the cb_i slice selected by cmd_o (zero if invalid) into status_o[CALLBACK_WIDTH-1:0], echo cmd_o into status_o[27:24], set status_o[31], and go to IDLE.
REQ-021 Latency: toggle edge to status_o[31]=1 SHALL be WAIT_CYCLES+3 cycles.
REQ-022 A toggle detected outside IDLE SHALL be dropped and SHALL set status_o[29]; the bit clears only on reset.
REQ-023 A toggle in the same cycle as the LATCH->IDLE transition SHALL count as overrun.
REQ-024 status_o[30] SHALL be rewritten on every issue; all status bits SHALL change only on the edges defined above.

Reset
REQ-025 While rst_i=1: state IDLE, counter 0, cmd_o 0, payload_o 0, en_o 0, status_o 0.
REQ-026 While rst_i=1, the strobe register SHALL load the current cmd_word_i[31], so the release of reset does not produce a spurious command.
REQ-027 Reset asserted mid-operation SHALL abort the command with no further en_o pulse.

Structure
REQ-028 The state_t enum and status bit-index constants SHALL live in a shared pdh_pkg.
REQ-029 The callback slice mux SHALL be a sub-module, cb_select, that is purely combinational.

Verification
REQ-030 Scenario: reset, toggle with cmd=1, payload=0xA5, target-1 cb=0xA5 -> one en_o pulse 2 cycles after the toggle; status_o=0x8100_00A5 at 7 cycles.
REQ-031 Scenario: cmd=7 with N_TARGETS=4 -> no en_o pulse; status_o[31:30]=2'b11; callback field 0x00.
REQ-032 Scenario: second toggle 3 cycles after the first -> dropped; a single en_o pulse; status_o[29]=1 and stays 1 across further commands.
REQ-033 Scenario: rst_i asserted during WAIT -> all outputs 0 asynchronously; after release, no en_o pulse until a new toggle.
REQ-034 Scenario: cmd_word_i[31]=1 held through reset release -> no command issued.
REQ-035 Scenario: back-to-back commands cmd=2 then cmd=0, each toggled after done -> two pulses; echoes 2 then 0; the correct cb slices are captured.

Source files
------------

// File: rtl/pdh_pkg.sv
// Shared definitions for the command dispatcher: FSM state type, status word
// bit positions and command-word field positions.
package pdh_pkg;

   // Dispatcher FSM states; all four 2-bit codes are in use.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   // Status word layout.
   localparam int STAT_DONE    = 31;
   localparam int STAT_INVALID = 30;
   localparam int STAT_OVERRUN = 29;
   localparam int STAT_CMD_LSB = 24;
   localparam int STAT_CMD_W   = 4;

   // Command word layout (PS register).
   localparam int STROBE_BIT   = 31;
   localparam int CMD_LSB      = 24;

   // A command code addresses a real target only below the target count.
   function automatic logic cmd_is_valid(input logic [31:0] code,
                                         input int unsigned n_targets);
      return code < n_targets;
   endfunction

endpackage

// File: rtl/cmd_dispatch_cb_select.sv
// Callback slice multiplexer: picks target sel's callback out of the packed
// callback bus; a code with no matching target yields zero.
module cb_select
   import pdh_pkg::*;
#(
   parameter int CMD_WIDTH      = 4,
   parameter int CALLBACK_WIDTH = 8,
   parameter int N_TARGETS      = 4
) (
   input  logic [N_TARGETS*CALLBACK_WIDTH-1:0] cb_all,
   input  logic [CMD_WIDTH-1:0]                sel,
   output logic [CALLBACK_WIDTH-1:0]           cb
);

   logic [CALLBACK_WIDTH-1:0] slice [N_TARGETS];
   logic [N_TARGETS-1:0]      hit;

   // Unpack each target slice and decode a one-hot hit per target.
   generate
      for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_slice
         assign slice[gi] = cb_all[gi*CALLBACK_WIDTH +: CALLBACK_WIDTH];
         assign hit[gi]   = (32'(sel) == 32'(gi));
      end
   endgenerate

   // AND-OR mux over the one-hot hits; no hit leaves the result at zero.
   always_comb begin
      cb = '0;
      for (int k = 0; k < N_TARGETS; k++) begin
         cb = cb | (slice[k] & {CALLBACK_WIDTH{hit[k]}});
      end
   end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: watches a toggle strobe in the PS command register,
// issues the command and payload to the targets with a one-cycle enable,
// waits for the target to respond, then latches its callback into status.
module cmd_dispatch
   import pdh_pkg::*;
#(
   parameter int CMD_WIDTH      = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int CALLBACK_WIDTH = 8,
   parameter int N_TARGETS      = 4,
   parameter int WAIT_CYCLES    = 4
) (
   input  logic                                clk,
   input  logic                                rst_i,
   input  logic [31:0]                         cmd_word_i,
   input  logic [N_TARGETS*CALLBACK_WIDTH-1:0] cb_i,
   output logic [CMD_WIDTH-1:0]                cmd_o,
   output logic [DATA_WIDTH-1:0]               payload_o,
   output logic                                en_o,
   output logic [31:0]                         status_o
);

   localparam int                CNT_W    = $clog2(WAIT_CYCLES) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   state_t                    state_reg;
   logic [CNT_W-1:0]          cnt_reg;
   logic [CMD_WIDTH-1:0]      cmd_reg;
   logic [DATA_WIDTH-1:0]     payload_reg;
   logic                      en_reg;
   logic                      done_reg;
   logic                      invalid_reg;
   logic                      overrun_reg;
   logic [STAT_CMD_W-1:0]     echo_reg;
   logic [CALLBACK_WIDTH-1:0] cb_reg;

   logic                      strobe_reg;
   logic                      strobe_prev_reg;
   logic                      toggle;
   logic [CMD_WIDTH-1:0]      cmd_field;
   logic                      new_cmd_valid;
   logic                      cur_cmd_valid;
   logic [CALLBACK_WIDTH-1:0] cb_sel;
   logic                      unused_cmd_word;

   // Only a few command-word fields are consumed; fold the rest away.
   assign unused_cmd_word = ^cmd_word_i;

   assign cmd_field     = cmd_word_i[CMD_LSB +: CMD_WIDTH];
   assign new_cmd_valid = cmd_is_valid(32'(cmd_field), N_TARGETS);
   assign cur_cmd_valid = cmd_is_valid(32'(cmd_reg), N_TARGETS);
   assign toggle        = strobe_reg ^ strobe_prev_reg;

   // Strobe history; during reset both stages track the live bit so that a
   // strobe level held across reset release is never seen as a toggle.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         strobe_reg      <= cmd_word_i[STROBE_BIT];
         strobe_prev_reg <= cmd_word_i[STROBE_BIT];
      end else begin
         strobe_reg      <= cmd_word_i[STROBE_BIT];
         strobe_prev_reg <= strobe_reg;
      end
   end

   cb_select #(
      .CMD_WIDTH      (CMD_WIDTH),
      .CALLBACK_WIDTH (CALLBACK_WIDTH),
      .N_TARGETS      (N_TARGETS)
   ) u_cb_select (
      .cb_all (cb_i),
      .sel    (cmd_reg),
      .cb     (cb_sel)
   );

   // Dispatch FSM with issue registers and status fields.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         cmd_reg     <= '0;
         payload_reg <= '0;
         en_reg      <= 1'b0;
         done_reg    <= 1'b0;
         invalid_reg <= 1'b0;
         overrun_reg <= 1'b0;
         echo_reg    <= '0;
         cb_reg      <= '0;
      end else begin
         en_reg <= 1'b0;
         // A new command while busy (LATCH included) is dropped but recorded.
         if (toggle && (state_reg != ST_IDLE)) begin
            overrun_reg <= 1'b1;
         end
         case (state_reg)
            ST_IDLE: begin
               if (toggle) begin
                  state_reg   <= ST_ISSUE;
                  cmd_reg     <= cmd_field;
                  payload_reg <= cmd_word_i[DATA_WIDTH-1:0];
                  done_reg    <= 1'b0;
                  invalid_reg <= ~new_cmd_valid;
               end
            end
            ST_ISSUE: begin
               en_reg    <= cur_cmd_valid;
               cnt_reg   <= '0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= ST_LATCH;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            ST_LATCH: begin
               cb_reg    <= cb_sel;
               echo_reg  <= STAT_CMD_W'(cmd_reg);
               done_reg  <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_o     = cmd_reg;
   assign payload_o = payload_reg;
   assign en_o      = en_reg;

   // Assemble the status word from its individually registered fields.
   always_comb begin
      status_o                                 = '0;
      status_o[STAT_DONE]                      = done_reg;
      status_o[STAT_INVALID]                   = invalid_reg;
      status_o[STAT_OVERRUN]                   = overrun_reg;
      status_o[STAT_CMD_LSB +: STAT_CMD_W]     = echo_reg;
      status_o[CALLBACK_WIDTH-1:0]             = cb_reg;
   end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: directed scenarios plus randomized
// commands, checked cycle by cycle against a transaction-level model.
module tb_cmd_dispatch;

   localparam int CMD_WIDTH      = 4;
   localparam int DATA_WIDTH     = 8;
   localparam int CALLBACK_WIDTH = 8;
   localparam int N_TARGETS      = 4;
   localparam int WAIT_CYCLES    = 4;
   localparam int EN_AT          = 2;
   localparam int DONE_AT        = WAIT_CYCLES + 3;

   logic                                clk = 1'b0;
   logic                                rst_i = 1'b1;
   logic [31:0]                         cmd_word_i = '0;
   logic [N_TARGETS*CALLBACK_WIDTH-1:0] cb_i = '0;
   logic [CMD_WIDTH-1:0]                cmd_o;
   logic [DATA_WIDTH-1:0]               payload_o;
   logic                                en_o;
   logic [31:0]                         status_o;

   int checks = 0;
   int errors = 0;

   logic [CALLBACK_WIDTH-1:0] cb_arr [N_TARGETS];
   bit                        ovr_model = 1'b0;

   cmd_dispatch #(
      .CMD_WIDTH      (CMD_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .CALLBACK_WIDTH (CALLBACK_WIDTH),
      .N_TARGETS      (N_TARGETS),
      .WAIT_CYCLES    (WAIT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .cmd_word_i (cmd_word_i),
      .cb_i       (cb_i),
      .cmd_o      (cmd_o),
      .payload_o  (payload_o),
      .en_o       (en_o),
      .status_o   (status_o)
   );

   always #5 clk = ~clk;

   task automatic pack_cb();
      for (int k = 0; k < N_TARGETS; k++) begin
         cb_i[k*CALLBACK_WIDTH +: CALLBACK_WIDTH] = cb_arr[k];
      end
   endtask

   // One command: toggle the strobe, then follow it cycle by cycle.
   // extra_at > 0 toggles the strobe again so it is sampled on that edge.
   task automatic run_cmd(input int cmd, input int payload, input int extra_at,
                          input string tag);
      bit          valid;
      logic [31:0] exp;
      int          en_seen;
      valid   = (cmd < N_TARGETS);
      en_seen = 0;
      if (extra_at > 0) ovr_model = 1'b1;
      exp = 32'h8000_0000;
      if (!valid) exp = exp | 32'h4000_0000;
      if (ovr_model) exp = exp | 32'h2000_0000;
      exp = exp | (32'(cmd) << 24);
      if (valid) exp = exp | 32'(cb_arr[cmd]);

      @(negedge clk);
      cmd_word_i = {~cmd_word_i[31], 3'b000, 4'(cmd), 16'h0000, 8'(payload)};
      @(posedge clk);
      #1;
      checks++;
      if (en_o !== 1'b0) begin
         errors++;
         $display("FAIL %s en_early: got %b expected 0", tag, en_o);
      end
      for (int k = 1; k <= DONE_AT + 1; k++) begin
         @(negedge clk);
         if (k == extra_at) cmd_word_i[31] = ~cmd_word_i[31];
         @(posedge clk);
         #1;
         if (en_o === 1'b1) en_seen++;
         checks++;
         if (en_o !== ((k == EN_AT) && valid)) begin
            errors++;
            $display("FAIL %s en_c%0d: got %b expected %b", tag, k, en_o,
                     (k == EN_AT) && valid);
         end
         if (k == 1) begin
            checks++;
            if (cmd_o !== 4'(cmd) || payload_o !== 8'(payload)) begin
               errors++;
               $display("FAIL %s issue: got cmd=%0d payload=%02h expected cmd=%0d payload=%02h",
                        tag, cmd_o, payload_o, cmd, payload);
            end
         end
         if (k < DONE_AT) begin
            checks++;
            if (status_o[31] !== 1'b0) begin
               errors++;
               $display("FAIL %s done_c%0d: got %b expected 0", tag, k, status_o[31]);
            end
         end else begin
            checks++;
            if (status_o !== exp) begin
               errors++;
               $display("FAIL %s status_c%0d: got %08h expected %08h", tag, k, status_o, exp);
            end
         end
      end
      $display("txn %s cmd=%0d payload=%02h extra=%0d en_pulses=%0d status=%08h",
               tag, cmd, payload, extra_at, en_seen, status_o);
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if (cmd_o !== '0 || payload_o !== '0 || en_o !== 1'b0 || status_o !== '0) begin
         errors++;
         $display("FAIL %s outputs: got cmd=%0d payload=%02h en=%b status=%08h expected all 0",
                  tag, cmd_o, payload_o, en_o, status_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst_i = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_idle_outputs("reset_release");
      end
      ovr_model = 1'b0;
      $display("txn reset status=%08h", status_o);
   endtask

   task automatic test_basic();
      cb_arr[0] = 8'h11; cb_arr[1] = 8'hA5; cb_arr[2] = 8'h3C; cb_arr[3] = 8'hF0;
      pack_cb();
      run_cmd(1, 8'hA5, 0, "basic");
   endtask

   task automatic test_invalid();
      run_cmd(7, 8'h42, 0, "invalid");
   endtask

   task automatic test_back_to_back();
      cb_arr[0] = 8'h5E; cb_arr[2] = 8'hC3;
      pack_cb();
      run_cmd(2, 8'h01, 0, "b2b_first");
      run_cmd(0, 8'h02, 0, "b2b_second");
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         for (int k = 0; k < N_TARGETS; k++) cb_arr[k] = 8'($urandom_range(0, 255));
         pack_cb();
         run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 0, "random");
      end
   endtask

   task automatic test_overrun();
      run_cmd(0, 8'h11, 3, "overrun");
      run_cmd(3, 8'h22, 0, "overrun_sticky");
   endtask

   task automatic test_reset_mid();
      int en_seen;
      en_seen = 0;
      @(negedge clk);
      cmd_word_i = {~cmd_word_i[31], 3'b000, 4'd3, 16'h0000, 8'h5A};
      repeat (4) @(posedge clk);
      #3;
      rst_i = 1'b1;
      #1;
      check_idle_outputs("reset_mid_async");
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      ovr_model = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (en_o === 1'b1) en_seen++;
         check_idle_outputs("reset_mid_after");
      end
      $display("txn reset_mid en_pulses=%0d status=%08h", en_seen, status_o);
   endtask

   task automatic test_reset_held();
      @(negedge clk);
      rst_i = 1'b1;
      cmd_word_i[31] = ~cmd_word_i[31];
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         check_idle_outputs("reset_held");
      end
      $display("txn reset_held strobe=%b status=%08h", cmd_word_i[31], status_o);
      cb_arr[1] = 8'h77;
      pack_cb();
      run_cmd(1, 8'h99, 0, "after_reset");
   endtask

   task automatic test_overrun_latch();
      run_cmd(2, 8'h33, DONE_AT - 1, "overrun_latch");
      run_cmd(1, 8'h44, 0, "overrun_latch_sticky");
   endtask

   initial begin
      for (int k = 0; k < N_TARGETS; k++) cb_arr[k] = '0;
      test_reset();
      test_basic();
      test_invalid();
      test_back_to_back();
      test_random();
      test_overrun();
      test_reset_mid();
      test_reset_held();
      test_overrun_latch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
